// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for ram_access_ctrl: FSM state encodings, MEM access size
// codes, the IO window base, and the size-to-byte-count helper.
package ram_access_ctrl_pkg;

    // FSM states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    // mem_size encodings (2'b11 is treated as a word as well)
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // IO space starts here (addr[17:16] == 2'b11); it shares the RAM path
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    // Number of byte transfers for a MEM access size code
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_to_len = 3'd1;
            MEM_SIZE_H: size_to_len = 3'd2;
            MEM_SIZE_W: size_to_len = 3'd4;
            default:    size_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: byte-serial RAM controller arbitrating IF fetches against
// MEM loads/stores. Accesses are split into byte transfers on the 8-bit RAM bus
// and words are assembled/scattered little-endian.
// Optional feature: define RAM_CTRL_DBG_CNT_EN to add dbg_if_cnt/dbg_mem_cnt
// completed-access counters.
//
// Handshake: a requester holds req until its one-cycle done pulse (or, for IF,
// until it flushes); data outputs are valid in the done cycle and then hold.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
`ifdef RAM_CTRL_DBG_CNT_EN
    ,
    output logic [CNT_W-1:0]  dbg_if_cnt,
    output logic [CNT_W-1:0]  dbg_mem_cnt
`endif
);

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;      // index of the next byte address to issue
    logic [2:0]        r_len;      // bytes in the current access
    logic              r_pend;     // byte r_cnt-1 was issued last cycle, data on ram_din now
    logic              r_is_if;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic              w_last_read;
    logic              w_if_done;
    logic              w_mem_done_rd;
    logic              w_mem_done_wr;
    logic              w_issue;
    logic [4:0]        w_cap_sh;
    logic [31:0]       w_asm_next;

    // A read finishes once the last issued byte is on ram_din
    assign w_last_read   = (r_state == ST_READ) && r_pend && (r_cnt == r_len);
    assign w_if_done     = rdy_in && w_last_read && r_is_if && !if_flush;
    assign w_mem_done_rd = rdy_in && w_last_read && !r_is_if;
    assign w_mem_done_wr = rdy_in && (r_state == ST_WRITE) && (r_cnt == r_len - 3'd1);

    // Merge the byte arriving this cycle into its little-endian lane
    assign w_cap_sh   = {2'(r_cnt - 3'd1), 3'b000};
    assign w_asm_next = r_asm | ({24'd0, ram_din} << w_cap_sh);

    assign w_issue = ((r_state == ST_READ) && (r_cnt != r_len)) || (r_state == ST_WRITE);

    assign if_done   = w_if_done;
    assign if_data   = w_if_done ? w_asm_next : r_if_data;
    assign mem_done  = w_mem_done_rd || w_mem_done_wr;
    assign mem_rdata = w_mem_done_rd ? w_asm_next : r_mem_rdata;
    assign ram_a     = w_issue ? (r_base + {{(ADDR_W-3){1'b0}}, r_cnt}) : '0;
    assign ram_wr    = rdy_in && (r_state == ST_WRITE);
    assign ram_dout  = (r_state == ST_WRITE) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
    assign busy      = (r_state != ST_IDLE);

    // Main FSM: accept, sequence byte transfers, assemble read data
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_pend      <= 1'b0;
            r_is_if     <= 1'b0;
            r_base      <= '0;
            r_wdata     <= 32'd0;
            r_asm       <= 32'd0;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_req) begin
                        r_state <= mem_we ? ST_WRITE : ST_READ;
                        r_len   <= size_to_len(mem_size);
                        r_base  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_is_if <= 1'b0;
                        r_cnt   <= 3'd0;
                        r_pend  <= 1'b0;
                        r_asm   <= 32'd0;
                    end else if (if_req && !if_flush) begin
                        r_state <= ST_READ;
                        r_len   <= 3'd4;
                        r_base  <= if_addr;
                        r_is_if <= 1'b1;
                        r_cnt   <= 3'd0;
                        r_pend  <= 1'b0;
                        r_asm   <= 32'd0;
                    end
                end
                ST_READ: begin
                    if (r_is_if && if_flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                        r_pend  <= 1'b0;
                    end else begin
                        if (r_pend)
                            r_asm <= w_asm_next;
                        if (r_cnt == r_len) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 3'd0;
                            r_pend  <= 1'b0;
                            if (r_is_if)
                                r_if_data <= w_asm_next;
                            else
                                r_mem_rdata <= w_asm_next;
                        end else begin
                            r_cnt  <= r_cnt + 3'd1;
                            r_pend <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == r_len - 3'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end else begin
            // Stalled: the byte in flight is lost, so step back and re-issue it
            if ((r_state == ST_READ) && r_pend) begin
                r_cnt  <= r_cnt - 3'd1;
                r_pend <= 1'b0;
            end
        end
    end

`ifdef RAM_CTRL_DBG_CNT_EN
    logic [CNT_W-1:0] r_if_cnt;
    logic [CNT_W-1:0] r_mem_cnt;

    // Count completed accesses; done pulses are already suppressed while stalled
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_if_cnt  <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_if_done)
                r_if_cnt <= r_if_cnt + CNT_W'(1);
            if (w_mem_done_rd || w_mem_done_wr)
                r_mem_cnt <= r_mem_cnt + CNT_W'(1);
        end
    end

    assign dbg_if_cnt  = r_if_cnt;
    assign dbg_mem_cnt = r_mem_cnt;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus randomized
// fetch/load/store traffic against a byte-array memory reference model.
module tb_ram_access_ctrl;
    import ram_access_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk_in = ~clk_in;

    ram_access_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
        .ram_wr(ram_wr), .busy(busy)
    );

    // memories: ram is the bus-side model, ref_mem is the transaction-level reference
    logic [7:0]  ram     [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [39:0] wr_log[$];
    logic [39:0] exp_q[$];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++)
            w = w | ({24'd0, ref_rd(a + 32'(k))} << (8 * k));
        return w;
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // mode 0: always ready; 1: random stalls; 2: stalled in cycles 2..4
    function automatic logic rdy_for(input int mode, input int cyc);
        if (mode == 1) return (cyc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(cyc >= 2 && cyc <= 4);
        return 1'b1;
    endfunction

    // RAM: registered read (data one cycle after address), write on ram_wr
    always @(posedge clk_in) begin
        if (ram_wr === 1'b1) begin
            ram[ram_a] = ram_dout;
            wr_log.push_back({ram_a, ram_dout});
        end
        ram_din <= ram_rd(ram_a);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    // driver: one IF fetch from idle, checking latency, bus and data
    task automatic run_if(input logic [31:0] addr, input int mode);
        logic [31:0] exp_d;
        int cyc;
        bit seen;
        exp_d = ref_word(addr, 4);
        if_req = 1'b1; if_addr = addr; if_flush = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 80) begin
            rdy_in = rdy_for(mode, cyc);
            #2;
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b0 || ram_wr !== 1'b0)
                    begin errors++; $display("FAIL if_accept busy=%b ram_wr=%b exp 0 0", busy, ram_wr); end
            end
            if (mode == 0 && cyc >= 1 && cyc <= 4) begin
                checks++;
                if (ram_a !== addr + 32'(cyc - 1) || ram_wr !== 1'b0)
                    begin errors++; $display("FAIL if_ram_a cyc=%0d got %h wr=%b exp %h", cyc, ram_a, ram_wr, addr + 32'(cyc - 1)); end
            end
            if (!rdy_in) begin
                checks++;
                if (ram_wr !== 1'b0 || if_done !== 1'b0)
                    begin errors++; $display("FAIL if_stall ram_wr=%b if_done=%b exp 0 0", ram_wr, if_done); end
            end
            checks++;
            if (mem_done !== 1'b0)
                begin errors++; $display("FAIL if_no_mem_done got %b exp 0", mem_done); end
            if (if_done === 1'b1) begin
                seen = 1;
                if (mode == 0) begin
                    checks++;
                    if (cyc != 5) begin errors++; $display("FAIL if_latency got %0d exp 5", cyc); end
                end
                checks++;
                if (if_data !== exp_d)
                    begin errors++; $display("FAIL if_data addr=%h got %h exp %h", addr, if_data, exp_d); end
            end
            step();
            cyc++;
        end
        if_req = 1'b0; rdy_in = 1'b1;
        checks++;
        if (!seen) begin errors++; $display("FAIL if_timeout addr=%h got no if_done exp if_done", addr); end
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL if_idle_after busy=%b exp 0", busy); end
        step();
    endtask

    // driver: one MEM load/store from idle
    task automatic run_mem(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input int mode);
        logic [31:0] exp_d;
        logic [39:0] got;
        int n;
        int cyc;
        bit seen;
        n = size_bytes(sz);
        exp_d = ref_word(addr, n);
        wr_log.delete();
        mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = addr; mem_wdata = wd;
        cyc = 0; seen = 0;
        while (!seen && cyc < 80) begin
            rdy_in = rdy_for(mode, cyc);
            #2;
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b0 || ram_wr !== 1'b0)
                    begin errors++; $display("FAIL mem_accept busy=%b ram_wr=%b exp 0 0", busy, ram_wr); end
            end
            if (mode == 0 && cyc >= 1 && cyc <= n) begin
                checks++;
                if (ram_a !== addr + 32'(cyc - 1) || ram_wr !== we)
                    begin errors++; $display("FAIL mem_ram_a cyc=%0d got %h wr=%b exp %h wr=%b", cyc, ram_a, ram_wr, addr + 32'(cyc - 1), we); end
                if (we) begin
                    checks++;
                    if (ram_dout !== wd[8*(cyc-1) +: 8])
                        begin errors++; $display("FAIL mem_ram_dout cyc=%0d got %h exp %h", cyc, ram_dout, wd[8*(cyc-1) +: 8]); end
                end
            end
            if (!rdy_in) begin
                checks++;
                if (ram_wr !== 1'b0 || mem_done !== 1'b0)
                    begin errors++; $display("FAIL mem_stall ram_wr=%b mem_done=%b exp 0 0", ram_wr, mem_done); end
            end
            checks++;
            if (if_done !== 1'b0)
                begin errors++; $display("FAIL mem_no_if_done got %b exp 0", if_done); end
            if (mem_done === 1'b1) begin
                seen = 1;
                if (mode == 0) begin
                    checks++;
                    if (cyc != (we ? n : n + 1))
                        begin errors++; $display("FAIL mem_latency got %0d exp %0d", cyc, we ? n : n + 1); end
                end
                if (!we) begin
                    checks++;
                    if (mem_rdata !== exp_d)
                        begin errors++; $display("FAIL mem_rdata addr=%h got %h exp %h", addr, mem_rdata, exp_d); end
                end
            end
            step();
            cyc++;
        end
        mem_req = 1'b0; rdy_in = 1'b1;
        checks++;
        if (!seen) begin errors++; $display("FAIL mem_timeout addr=%h got no mem_done exp mem_done", addr); end
        if (we) begin
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                ref_mem[addr + 32'(k)] = wd[8*k +: 8];
                exp_q.push_back({addr + 32'(k), wd[8*k +: 8]});
            end
            checks++;
            if (wr_log.size() != exp_q.size())
                begin errors++; $display("FAIL wr_count got %0d exp %0d", wr_log.size(), exp_q.size()); end
            while (exp_q.size() > 0 && wr_log.size() > 0) begin
                got = wr_log.pop_front();
                checks++;
                if (got !== exp_q[0])
                    begin errors++; $display("FAIL wr_order got %h exp %h", got, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mem_idle_after busy=%b exp 0", busy); end
        step();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step(); step();
        #2;
        checks++;
        if ({if_done, mem_done, ram_wr, busy} !== 4'b0)
            begin errors++; $display("FAIL reset_ctl got %b exp 0000", {if_done, mem_done, ram_wr, busy}); end
        checks++;
        if (ram_a !== 32'd0 || ram_dout !== 8'd0)
            begin errors++; $display("FAIL reset_bus ram_a=%h ram_dout=%h exp 0 0", ram_a, ram_dout); end
        checks++;
        if (if_data !== 32'd0 || mem_rdata !== 32'd0)
            begin errors++; $display("FAIL reset_data if_data=%h mem_rdata=%h exp 0 0", if_data, mem_rdata); end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_fetch_word();
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        run_if(32'h100, 0);
        #2;
        checks++;
        if (if_data !== 32'h0000_0513)
            begin errors++; $display("FAIL fetch_hold got %h exp 00000513", if_data); end
        step();
    endtask

    task automatic test_tie();
        int cyc;
        bit seen;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = MEM_SIZE_B; mem_addr = IO_BASE;
        mem_wdata = {$urandom_range(0, 255) % 256, 8'h00, 8'h00, 8'hAB};
        if_req = 1'b1; if_addr = 32'h100;
        #2;
        checks++;
        if (busy !== 1'b0 || ram_wr !== 1'b0)
            begin errors++; $display("FAIL tie_accept busy=%b ram_wr=%b exp 0 0", busy, ram_wr); end
        step();
        #2;
        checks++;
        if ({ram_wr, mem_done, if_done} !== 3'b110 || ram_a !== IO_BASE || ram_dout !== 8'hAB)
            begin errors++; $display("FAIL tie_store wr/md/id=%b a=%h d=%h exp 110 %h ab", {ram_wr, mem_done, if_done}, ram_a, ram_dout, IO_BASE); end
        step();
        mem_req = 1'b0;
        ref_mem[IO_BASE] = 8'hAB;
        #2;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL tie_idle busy=%b exp 0", busy); end
        step();
        cyc = 3; seen = 0;
        while (!seen && cyc < 20) begin
            #2;
            if (if_done === 1'b1) begin
                seen = 1;
                checks++;
                if (cyc != 7 || if_data !== ref_word(32'h100, 4))
                    begin errors++; $display("FAIL tie_fetch cyc=%0d data=%h exp 7 %h", cyc, if_data, ref_word(32'h100, 4)); end
            end
            step();
            cyc++;
        end
        if_req = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL tie_timeout got no if_done exp if_done"); end
        checks++;
        if (ram_rd(IO_BASE) !== 8'hAB)
            begin errors++; $display("FAIL tie_ram got %h exp ab", ram_rd(IO_BASE)); end
        step();
    endtask

    task automatic test_half_load();
        preload(32'h1FFFF, 8'h34); preload(32'h20000, 8'h12);
        run_mem(1'b0, MEM_SIZE_H, 32'h1FFFF, 32'd0, 0);
        #2;
        checks++;
        if (mem_rdata !== 32'h0000_1234)
            begin errors++; $display("FAIL half_load got %h exp 00001234", mem_rdata); end
        step();
    endtask

    task automatic test_flush();
        int f;
        for (int t = 0; t < 4; t++) begin
            f = (t == 0) ? 2 : $urandom_range(1, 5);
            if_req = 1'b1; if_addr = $urandom_range(0, 255) * 4; rdy_in = 1'b1;
            for (int c = 0; c <= f; c++) begin
                if (c == f) if_flush = 1'b1;
                #2;
                checks++;
                if (if_done !== 1'b0)
                    begin errors++; $display("FAIL flush_no_done at=%0d c=%0d got %b exp 0", f, c, if_done); end
                step();
            end
            if_flush = 1'b0;
            #2;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle at=%0d busy=%b exp 0", f, busy); end
            run_if(32'h200 + 32'(t * 8), 0);
        end
    endtask

    task automatic test_rdy_store();
        run_mem(1'b1, MEM_SIZE_W, 32'h400, 32'hDEAD_BEEF, 2);
        run_mem(1'b0, MEM_SIZE_W, 32'h400, 32'd0, 0);
        #2;
        checks++;
        if (mem_rdata !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL rdy_store_readback got %h exp deadbeef", mem_rdata); end
        step();
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1; if_addr = 32'h340;
        step(); step(); step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0; if_req = 1'b0;
        #2;
        checks++;
        if ({if_done, mem_done, ram_wr, busy} !== 4'b0 || ram_a !== 32'd0 || ram_dout !== 8'd0
            || if_data !== 32'd0 || mem_rdata !== 32'd0)
            begin errors++; $display("FAIL reset_mid ctl=%b a=%h d=%h ifd=%h md=%h exp all 0", {if_done, mem_done, ram_wr, busy}, ram_a, ram_dout, if_data, mem_rdata); end
        step();
        for (int c = 0; c < 8; c++) begin
            #2;
            checks++;
            if (if_done !== 1'b0 || mem_done !== 1'b0)
                begin errors++; $display("FAIL reset_mid_done c=%0d if=%b mem=%b exp 0 0", c, if_done, mem_done); end
            step();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int op;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h0000_0100 + 32'($urandom_range(0, 63));
                1: a = IO_BASE + 32'($urandom_range(0, 31));
                2: a = 32'h0001_FFF0 + 32'($urandom_range(0, 31));
                default: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            endcase
            op = $urandom_range(0, 2);
            if (op == 0)
                run_if(a, $urandom_range(0, 1));
            else
                run_mem(op == 2, 2'($urandom_range(0, 3)), a, $urandom, $urandom_range(0, 1));
        end
    endtask

    task automatic test_mem_image();
        foreach (ref_mem[a]) begin
            checks++;
            if (ram_rd(a) !== ref_mem[a])
                begin errors++; $display("FAIL mem_image addr=%h got %h exp %h", a, ram_rd(a), ref_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_word();
        test_tie();
        test_half_load();
        test_flush();
        test_rdy_store();
        test_reset_mid();
        test_random();
        test_mem_image();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
